// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, sync byte default and header field positions
package uart_pkg;
  typedef enum logic [2:0] {HUNT, HDR, ADDR, PAYLOAD, CHECK, FLUSH} state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int OP_HI = 7;
  localparam int OP_LO = 4;
  localparam int LEN_HI = 3;
  localparam int LEN_LO = 0;
endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: receiver byte stream plus downstream write port of the frame controller
//   rx_data/rx_valid/uart_ready : byte receiver side
//   wr_en/wr_addr/wr_data/wr_ready : buffer write port
//   master = frame controller, slave = receiver + buffer side
interface uart_rx_frame_ctrl_if #(parameter int ADDR_W = 8);
  logic [7:0] rx_data;
  logic rx_valid;
  logic uart_ready;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic wr_ready;
  modport master(input rx_data, rx_valid, wr_ready, output uart_ready, wr_en, wr_addr, wr_data);
  modport slave(output rx_data, rx_valid, wr_ready, input uart_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/uart_rx_frame_buf.sv
// uart_rx_frame_buf: payload staging register file, one write port, one combinational read port
//   clock : write clock
//   we/waddr/wdata : write port
//   raddr/rdata : read port
module uart_rx_frame_buf #(parameter int DEPTH = 16) (
  input  logic       clock,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles UART bytes into checksummed frames and flushes the payload to a write port
//   clock, reset : system clock, synchronous active-high reset
//   bus          : receiver bytes in, uart_ready throttle out, downstream write port out
//   frame_opcode : opcode of the last committed frame
//   frame_done   : one-cycle pulse, frame committed
//   frame_err    : one-cycle pulse, frame dropped
//   busy         : high outside HUNT
//   UART_RX_TIMEOUT_EN : adds an inter-byte timeout of TIMEOUT_CYCLES clocks
module uart_rx_frame_ctrl import uart_pkg::*; #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
`ifdef UART_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  uart_rx_frame_ctrl_if.master bus,
  output logic [3:0]          frame_opcode,
  output logic                frame_done,
  output logic                frame_err,
  output logic                busy
);
  state_t state, next;
  logic rx_q, byte_edge, last, chk_ok, commit, drop, tmo;
  logic [3:0] op, len, idx;
  logic [7:0] xsum, rd;
  logic [ADDR_W-1:0] base;
  // rx_valid stays high for many cycles per byte; only its rising edge is a byte
  assign byte_edge = bus.rx_valid & ~rx_q;
  assign last = idx == len;
  assign chk_ok = bus.rx_data == xsum;
  assign commit = state == FLUSH && bus.wr_ready && last;
`ifdef UART_RX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    cnt <= (reset || byte_edge || state == HUNT || state == FLUSH) ? '0 : cnt + 1'b1;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1) && !byte_edge;
`else
  assign tmo = 1'b0;
`endif
  assign drop = (state == CHECK && byte_edge && !chk_ok) || tmo;
  always_comb begin
    next = state;
    case (state)
      HUNT:    if (byte_edge && bus.rx_data == SYNC_BYTE) next = HDR;
      HDR:     if (byte_edge) next = ADDR;
      ADDR:    if (byte_edge) next = PAYLOAD;
      PAYLOAD: if (byte_edge && last) next = CHECK;
      CHECK:   if (byte_edge) next = chk_ok ? FLUSH : HUNT;
      FLUSH:   if (commit) next = HUNT;
      default: next = HUNT;
    endcase
    if (drop) next = HUNT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HUNT;
      rx_q <= 1'b0;
      op <= '0;
      len <= '0;
      idx <= '0;
      xsum <= '0;
      base <= '0;
      frame_opcode <= '0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= next;
      rx_q <= bus.rx_valid;
      frame_done <= commit;
      frame_err <= drop;
      if (commit) frame_opcode <= op;
      if (state == FLUSH && bus.wr_ready) idx <= idx + 1'b1;
      // byte edges during FLUSH fall through the default arm and are ignored
      if (byte_edge)
        case (state)
          HDR: begin
            op <= bus.rx_data[OP_HI:OP_LO];
            len <= bus.rx_data[LEN_HI:LEN_LO];
            xsum <= bus.rx_data;
          end
          ADDR: begin
            base <= ADDR_W'(bus.rx_data);
            xsum <= xsum ^ bus.rx_data;
            idx <= '0;
          end
          PAYLOAD: begin
            xsum <= xsum ^ bus.rx_data;
            idx <= last ? idx : idx + 1'b1;
          end
          CHECK: idx <= '0;
          default: ;
        endcase
    end
  end
  uart_rx_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clock(clock),
    .we(state == PAYLOAD && byte_edge),
    .waddr(idx),
    .wdata(bus.rx_data),
    .raddr(idx),
    .rdata(rd)
  );
  assign bus.uart_ready = state != FLUSH;
  assign bus.wr_en = state == FLUSH;
  assign bus.wr_addr = bus.wr_en ? base + ADDR_W'(idx) : '0;
  assign bus.wr_data = bus.wr_en ? rd : '0;
  assign busy = state != HUNT;
endmodule
